lbp_result_drain: RTL

// - Result-side counterpart of the LBP core's write port: owns the 128x128 LBP result buffer,

---
 rtl/lbp_pkg.sv | 13 +
 rtl/lbp_dp_ram.sv | 20 ++
 rtl/lbp_result_drain.sv | 117 +++++++++++
 3 files changed

// File: rtl/lbp_pkg.sv
// Shared constants and the drain FSM state type for the LBP result path.
package lbp_pkg;
    localparam int LBP_ADDR_W = 14;
    localparam int LBP_DATA_W = 8;
    localparam int LBP_IMG_W  = 128;
    localparam int LBP_DEPTH  = 16384;

    typedef enum logic [1:0] {
        DRN_IDLE  = 2'd0,
        DRN_DRAIN = 2'd1,
        DRN_DONE  = 2'd2
    } drn_state_e;
endpackage

// File: rtl/lbp_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency), no reset.
module lbp_dp_ram #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/lbp_result_drain.sv
// Captures LBP core writes into the result buffer, then streams the buffer out in address
// order over a valid/ready interface with a 2-entry skid FIFO behind the RAM read port.
module lbp_result_drain import lbp_pkg::*; #(
    parameter int ADDR_W = LBP_ADDR_W,
    parameter int DATA_W = LBP_DATA_W,
    parameter int DEPTH  = LBP_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    drn_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_rd_done;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_infl_addr;
    logic [DATA_W-1:0] w_ram_q;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic [ADDR_W-1:0] r_fifo_addr [2];
    logic              r_wr_idx, r_rd_idx;
    logic [1:0]        r_cnt;
    logic              w_start, w_issue, w_nonempty, w_hs, w_pop, w_push;

    assign w_start    = (r_state == DRN_IDLE) && finish;
    assign w_issue    = (r_state == DRN_DRAIN) && !r_rd_done
                        && ((r_cnt + {1'b0, r_inflight}) < 2'd2);
    assign w_nonempty = (r_cnt != 2'd0);

    // The RAM output is presented directly when the FIFO is empty; it only lands in the
    // FIFO if it was not taken that cycle, which gives the 2-cycle finish-to-valid latency.
    assign out_valid = w_nonempty | r_inflight;
    assign out_data  = w_nonempty ? r_fifo_data[r_rd_idx] : (r_inflight ? w_ram_q : '0);
    assign out_addr  = w_nonempty ? r_fifo_addr[r_rd_idx] : (r_inflight ? r_infl_addr : '0);
    assign out_last  = out_valid && (out_addr == LAST_ADDR);
    assign busy      = (r_state == DRN_DRAIN);
    assign done      = (r_state == DRN_DONE);

    assign w_hs   = out_valid & out_ready;
    assign w_pop  = w_hs & w_nonempty;
    assign w_push = r_inflight & (w_nonempty | ~out_ready);

    lbp_dp_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk     (clk),
        .i_we    ((r_state == DRN_IDLE) && lbp_valid),
        .i_waddr (lbp_addr),
        .i_wdata (lbp_data),
        .i_re    (w_issue),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= DRN_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DRN_IDLE:  if (finish) w_state_nxt = DRN_DRAIN;
            DRN_DRAIN: if (w_hs && out_last) w_state_nxt = DRN_DONE;
            DRN_DONE:  w_state_nxt = DRN_IDLE;
            default:   w_state_nxt = DRN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr    <= '0;
            r_rd_done   <= 1'b0;
            r_inflight  <= 1'b0;
            r_infl_addr <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_start) begin
                r_rd_ptr  <= '0;
                r_rd_done <= 1'b0;
            end else if (w_issue) begin
                r_infl_addr <= r_rd_ptr;
                if (r_rd_ptr == LAST_ADDR) r_rd_done <= 1'b1;
                else                       r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_addr[i] <= '0;
            end
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_idx] <= w_ram_q;
                r_fifo_addr[r_wr_idx] <= r_infl_addr;
                r_wr_idx              <= ~r_wr_idx;
            end
            if (w_pop) r_rd_idx <= ~r_rd_idx;
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end
endmodule
